// File: rtl/mx_pkg.sv
// Shared MX-format definitions: E8M0 scale constants, element format widths,
// and the product width that the element multiplier produces for a format.
package mx_pkg;

    localparam int E8M0_W = 8;
    localparam logic [E8M0_W-1:0] E8M0_NAN = 8'hFF;

    localparam int E5M2_EXP_W = 5;
    localparam int E5M2_MAN_W = 2;
    localparam int E4M3_EXP_W = 4;
    localparam int E4M3_MAN_W = 3;
    localparam int E3M2_EXP_W = 3;
    localparam int E3M2_MAN_W = 2;
    localparam int E2M3_EXP_W = 2;
    localparam int E2M3_MAN_W = 3;
    localparam int E2M1_EXP_W = 2;
    localparam int E2M1_MAN_W = 1;

    // Fixed-point product of two elements spans twice the full dynamic range.
    function automatic int prd_width_f(input int exp_w, input int man_w);
        return 2 * ((1 << exp_w) + man_w);
    endfunction

endpackage

// File: rtl/acc_fp_prd.sv
// Block accumulator: sums up to blk_size signed products into one exact MX block sum.
// Optional shared-scale combining is enabled by defining ACC_FP_PRD_SCL_EN.
//
// state | meaning
// ACC   | accepting product beats, accumulating the running block sum
// DONE  | block sum presented on o_sum/o_cnt, waiting for i_sum_ready
module acc_fp_prd
    import mx_pkg::*;
#(
    parameter int exp_width = E5M2_EXP_W,
    parameter int man_width = E5M2_MAN_W,
    parameter int prd_width = prd_width_f(exp_width, man_width),
    parameter int blk_size  = 32,
    parameter int cnt_width = $clog2(blk_size),
    parameter int acc_width = prd_width + cnt_width
`ifdef ACC_FP_PRD_SCL_EN
    , parameter int scl_width = E8M0_W
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_prd_valid,
    output logic                 o_prd_ready,
    input  logic [prd_width-1:0] i_prd,
    input  logic                 i_prd_last,
    output logic                 o_sum_valid,
    input  logic                 i_sum_ready,
    output logic [acc_width-1:0] o_sum,
    output logic [cnt_width:0]   o_cnt
`ifdef ACC_FP_PRD_SCL_EN
    , input  logic [scl_width-1:0] i_scl0
    , input  logic [scl_width-1:0] i_scl1
    , output logic [scl_width:0]   o_scl
`endif
);

    typedef enum logic {ST_ACC, ST_DONE} state_t;

    localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(blk_size - 1);

    state_t                       state;
    logic signed [acc_width-1:0]  acc;
    logic [cnt_width-1:0]         cnt;

    logic signed [acc_width-1:0]  prd_ext;
    logic signed [acc_width-1:0]  sum_nxt;
    logic [cnt_width:0]           cnt_nxt;
    logic                         beat;
    logic                         blk_end;

    always_comb begin
        prd_ext = acc_width'($signed(i_prd));
        sum_nxt = acc + prd_ext;
        cnt_nxt = {1'b0, cnt} + (cnt_width + 1)'(1);
        beat    = i_prd_valid && o_prd_ready;
        blk_end = i_prd_last || (cnt == CNT_LAST);
    end

`ifdef ACC_FP_PRD_SCL_EN
    logic [scl_width-1:0] scl0_q;
    logic [scl_width-1:0] scl1_q;
    logic [scl_width-1:0] scl0_use;
    logic [scl_width-1:0] scl1_use;
    logic [scl_width:0]   scl_nxt;

    // A single-beat block ends on its capture beat, so use the live inputs then.
    always_comb begin
        scl0_use = (cnt == '0) ? i_scl0 : scl0_q;
        scl1_use = (cnt == '0) ? i_scl1 : scl1_q;
        if ((scl0_use == scl_width'(E8M0_NAN)) || (scl1_use == scl_width'(E8M0_NAN)))
            scl_nxt = '1;
        else
            scl_nxt = {1'b0, scl0_use} + {1'b0, scl1_use};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl0_q <= '0;
            scl1_q <= '0;
            o_scl  <= '0;
        end else if (state == ST_ACC && beat) begin
            if (cnt == '0) begin
                scl0_q <= i_scl0;
                scl1_q <= i_scl1;
            end
            if (blk_end)
                o_scl <= scl_nxt;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_ACC;
            acc         <= '0;
            cnt         <= '0;
            o_sum       <= '0;
            o_cnt       <= '0;
            o_sum_valid <= 1'b0;
            o_prd_ready <= 1'b1;
        end else begin
            case (state)
                ST_ACC: begin
                    if (beat) begin
                        if (blk_end) begin
                            o_sum       <= sum_nxt;
                            o_cnt       <= cnt_nxt;
                            acc         <= '0;
                            cnt         <= '0;
                            o_sum_valid <= 1'b1;
                            o_prd_ready <= 1'b0;
                            state       <= ST_DONE;
                        end else begin
                            acc <= sum_nxt;
                            cnt <= cnt_nxt[cnt_width-1:0];
                        end
                    end
                end
                ST_DONE: begin
                    if (i_sum_ready) begin
                        o_sum_valid <= 1'b0;
                        o_prd_ready <= 1'b1;
                        state       <= ST_ACC;
                    end
                end
                default: begin
                    state       <= ST_ACC;
                    o_sum_valid <= 1'b0;
                    o_prd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_fp_prd.sv
// Directed bench for acc_fp_prd: per-cycle vector table plus hand-written block sequences.
// Scale checks are built only when ACC_FP_PRD_SCL_EN is defined.
module tb_acc_fp_prd;

    localparam int PRD_W = 68;
    localparam int CNT_W = 5;
    localparam int ACC_W = 73;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_prd_valid;
    logic               o_prd_ready;
    logic [PRD_W-1:0]   i_prd;
    logic               i_prd_last;
    logic               o_sum_valid;
    logic               i_sum_ready;
    logic [ACC_W-1:0]   o_sum;
    logic [CNT_W:0]     o_cnt;
`ifdef ACC_FP_PRD_SCL_EN
    logic [7:0]         i_scl0;
    logic [7:0]         i_scl1;
    logic [8:0]         o_scl;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    acc_fp_prd dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_prd_valid (i_prd_valid),
        .o_prd_ready (o_prd_ready),
        .i_prd       (i_prd),
        .i_prd_last  (i_prd_last),
        .o_sum_valid (o_sum_valid),
        .i_sum_ready (i_sum_ready),
        .o_sum       (o_sum),
        .o_cnt       (o_cnt)
`ifdef ACC_FP_PRD_SCL_EN
        , .i_scl0    (i_scl0)
        , .i_scl1    (i_scl1)
        , .o_scl     (o_scl)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic                     valid;
        logic                     last;
        logic signed [PRD_W-1:0]  prd;
        logic                     sum_ready;
        logic                     exp_sum_valid;
        logic                     exp_prd_ready;
        logic                     chk_sum;
        logic signed [ACC_W-1:0]  exp_sum;
        logic [CNT_W:0]           exp_cnt;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic v, input logic l, input logic signed [PRD_W-1:0] p,
                                input logic r, input logic esv, input logic epr, input logic cs,
                                input logic signed [ACC_W-1:0] es, input logic [CNT_W:0] ec);
        vec_t t;
        t.valid = v; t.last = l; t.prd = p; t.sum_ready = r;
        t.exp_sum_valid = esv; t.exp_prd_ready = epr; t.chk_sum = cs;
        t.exp_sum = es; t.exp_cnt = ec;
        return t;
    endfunction

    task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [PRD_W-1:0] p, input logic r);
        i_prd_valid = v;
        i_prd_last  = l;
        i_prd       = p;
        i_sum_ready = r;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    logic signed [PRD_W-1:0] prd_min;
    logic signed [PRD_W-1:0] prd_max;
    logic [ACC_W-1:0]        exp_min_sum;
    logic [ACC_W-1:0]        exp_max_sum;

    initial begin
        i_rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
`ifdef ACC_FP_PRD_SCL_EN
        i_scl0 = '0;
        i_scl1 = '0;
`endif
        step();
        step();
        i_rst = 1'b0;
        check("rst_sum_valid", ACC_W'(o_sum_valid), ACC_W'(0));
        check("rst_prd_ready", ACC_W'(o_prd_ready), ACC_W'(1));
        check("rst_sum",       o_sum,               ACC_W'(0));
        check("rst_cnt",       ACC_W'(o_cnt),       ACC_W'(0));
`ifdef ACC_FP_PRD_SCL_EN
        check("rst_scl",       ACC_W'(o_scl),       ACC_W'(0));
`endif

        // Full block of 32 x 16 ends on count alone.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, PRD_W'(16), 1'b1);
            step();
            if (i < 31)
                check("full_no_valid_early", ACC_W'(o_sum_valid), ACC_W'(0));
        end
        check("full_sum_valid", ACC_W'(o_sum_valid), ACC_W'(1));
        check("full_prd_ready", ACC_W'(o_prd_ready), ACC_W'(0));
        check("full_sum",       o_sum,               ACC_W'(512));
        check("full_cnt",       ACC_W'(o_cnt),       ACC_W'(32));
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        check("full_valid_drop", ACC_W'(o_sum_valid), ACC_W'(0));
        check("full_ready_back", ACC_W'(o_prd_ready), ACC_W'(1));

        // Early end, ignored last without valid, backpressure, then a fresh block.
        vecs[0]  = mk(1, 0,  100, 0, 0, 1, 0,   0, 0);
        vecs[1]  = mk(1, 0,  -40, 0, 0, 1, 0,   0, 0);
        vecs[2]  = mk(0, 1,  999, 0, 0, 1, 0,   0, 0);
        vecs[3]  = mk(1, 1,    7, 0, 1, 0, 1,  67, 3);
        vecs[4]  = mk(1, 0,   50, 0, 1, 0, 1,  67, 3);
        vecs[5]  = mk(1, 1,   50, 0, 1, 0, 1,  67, 3);
        vecs[6]  = mk(0, 0,    0, 0, 1, 0, 1,  67, 3);
        vecs[7]  = mk(0, 0,    0, 0, 1, 0, 1,  67, 3);
        vecs[8]  = mk(0, 0,    0, 0, 1, 0, 1,  67, 3);
        vecs[9]  = mk(1, 1,  999, 1, 0, 1, 0,   0, 0);
        vecs[10] = mk(1, 0,   -3, 0, 0, 1, 0,   0, 0);
        vecs[11] = mk(1, 1,   -5, 0, 1, 0, 1,  -8, 2);
        vecs[12] = mk(0, 0,    0, 1, 0, 1, 0,   0, 0);
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].last, vecs[i].prd, vecs[i].sum_ready);
            step();
            check($sformatf("vec%0d_sum_valid", i), ACC_W'(o_sum_valid), ACC_W'(vecs[i].exp_sum_valid));
            check($sformatf("vec%0d_prd_ready", i), ACC_W'(o_prd_ready), ACC_W'(vecs[i].exp_prd_ready));
            if (vecs[i].chk_sum) begin
                check($sformatf("vec%0d_sum", i), o_sum,         vecs[i].exp_sum);
                check($sformatf("vec%0d_cnt", i), ACC_W'(o_cnt), ACC_W'(vecs[i].exp_cnt));
            end
        end

        // Extreme products: exact sums reach the accumulator's signed limits.
        prd_min     = {1'b1, {(PRD_W-1){1'b0}}};
        prd_max     = {1'b0, {(PRD_W-1){1'b1}}};
        exp_min_sum = {1'b1, {(ACC_W-1){1'b0}}};
        exp_max_sum = {{(CNT_W+1){1'b0}}, {(PRD_W-1){1'b1}}, {CNT_W{1'b0}}};
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, prd_min, 1'b1);
            step();
        end
        check("min_sum", o_sum,         exp_min_sum);
        check("min_cnt", ACC_W'(o_cnt), ACC_W'(32));
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, prd_max, 1'b1);
            step();
        end
        check("max_sum", o_sum,         exp_max_sum);
        check("max_cnt", ACC_W'(o_cnt), ACC_W'(32));
        drive(1'b0, 1'b0, '0, 1'b1);
        step();

        // Reset mid-block discards the partial sum.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, PRD_W'(5), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("mid_rst_prd_ready", ACC_W'(o_prd_ready), ACC_W'(1));
        check("mid_rst_sum_valid", ACC_W'(o_sum_valid), ACC_W'(0));
        drive(1'b1, 1'b0, PRD_W'(3), 1'b0);
        step();
        drive(1'b1, 1'b1, PRD_W'(3), 1'b0);
        step();
        check("mid_rst_sum",   o_sum,               ACC_W'(6));
        check("mid_rst_cnt",   ACC_W'(o_cnt),       ACC_W'(2));
        check("mid_rst_valid", ACC_W'(o_sum_valid), ACC_W'(1));
        drive(1'b0, 1'b0, '0, 1'b1);
        step();

        // Single-beat block.
        drive(1'b1, 1'b1, PRD_W'(-9), 1'b0);
        step();
        check("single_sum", o_sum,         ACC_W'(-9));
        check("single_cnt", ACC_W'(o_cnt), ACC_W'(1));
        drive(1'b0, 1'b0, '0, 1'b1);
        step();

`ifdef ACC_FP_PRD_SCL_EN
        // Scales captured on the first beat; later changes ignored.
        i_scl0 = 8'd127; i_scl1 = 8'd130;
        drive(1'b1, 1'b0, PRD_W'(1), 1'b0);
        step();
        i_scl0 = 8'd1; i_scl1 = 8'd1;
        drive(1'b1, 1'b1, PRD_W'(1), 1'b0);
        step();
        check("scl_sum", ACC_W'(o_scl), ACC_W'(257));
        drive(1'b0, 1'b0, '0, 1'b0);
        i_scl0 = 8'd9;
        step();
        check("scl_hold", ACC_W'(o_scl), ACC_W'(257));
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        i_scl0 = 8'd255; i_scl1 = 8'd3;
        drive(1'b1, 1'b0, PRD_W'(1), 1'b0);
        step();
        i_scl0 = 8'd0;
        drive(1'b1, 1'b1, PRD_W'(1), 1'b0);
        step();
        check("scl_nan", ACC_W'(o_scl), ACC_W'(9'h1FF));
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
        i_scl0 = 8'd10; i_scl1 = 8'd20;
        drive(1'b1, 1'b1, PRD_W'(1), 1'b0);
        step();
        check("scl_single", ACC_W'(o_scl), ACC_W'(30));
        drive(1'b0, 1'b0, '0, 1'b1);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
